// File: rtl/serial_add_sched.sv
// Round-robin two-port scheduler driving one 1-bit add slice, LSB first, for WIDTH cycles.
// Define SERIAL_ADD_CARRY_EN for a true ripple add; otherwise the slice is carry-less (a ^ b).
module serial_add_sched #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in0_valid,
    output logic             in0_ready,
    input  logic [WIDTH-1:0] in0_a,
    input  logic [WIDTH-1:0] in0_b,
    input  logic             in1_valid,
    output logic             in1_ready,
    input  logic [WIDTH-1:0] in1_a,
    input  logic [WIDTH-1:0] in1_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             out_id,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic             grant;
    logic             grant_valid;
    logic             accept;
    logic             last_grant;
    logic             id_q;
    logic             bit_s;
    logic             bit_c;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH:0]   sum_ext;

    // Handshake: a transfer happens on a rising edge where valid && ready are both high;
    // a requester keeps valid and operands steady until it sees ready.
    always_comb begin
        grant_valid = in0_valid | in1_valid;
        if (in0_valid && in1_valid) begin
            grant = ~last_grant;
        end else begin
            grant = in1_valid;
        end
    end

    assign accept = (state == IDLE) && grant_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (idx == LAST_IDX) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in0_ready = (state == IDLE) && grant_valid && !grant;
        in1_ready = (state == IDLE) && grant_valid && grant;
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    // Operands shift right so the slice always reads bit 0; sums enter at the MSB.
    assign bit_s   = a_q[0] ^ b_q[0] ^ bit_c;
    assign sum_ext = {bit_s, sum_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            sum_q      <= '0;
            idx        <= '0;
            id_q       <= 1'b0;
            last_grant <= 1'b1;
        end else if (accept) begin
            a_q        <= grant ? in1_a : in0_a;
            b_q        <= grant ? in1_b : in0_b;
            sum_q      <= '0;
            idx        <= '0;
            id_q       <= grant;
            last_grant <= grant;
        end else if (state == RUN) begin
            a_q   <= a_q >> 1;
            b_q   <= b_q >> 1;
            sum_q <= sum_ext[WIDTH:1];
            idx   <= idx + 1'b1;
        end
    end

`ifdef SERIAL_ADD_CARRY_EN
    logic carry_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q <= 1'b0;
        end else if (accept) begin
            carry_q <= 1'b0;
        end else if (state == RUN) begin
            carry_q <= (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
        end
    end

    assign bit_c     = carry_q;
    assign out_carry = carry_q;
`else
    assign bit_c     = 1'b0;
    assign out_carry = 1'b0;
`endif

    assign out_sum = sum_q;
    assign out_id  = id_q;

endmodule

// File: tb/tb_serial_add_sched.sv
// Directed bench for serial_add_sched: WIDTH=8 instance plus a WIDTH=1 instance.
// Expected results come from a reference add model keyed on SERIAL_ADD_CARRY_EN.
module tb_serial_add_sched;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in0_valid = 1'b0, in1_valid = 1'b0;
    logic         in0_ready, in1_ready;
    logic [W-1:0] in0_a = '0, in0_b = '0, in1_a = '0, in1_b = '0;
    logic         out_valid, out_carry, out_id, busy;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_sum;

    logic w1_in0_valid = 1'b0, w1_in1_valid = 1'b0;
    logic w1_in0_ready, w1_in1_ready;
    logic w1_in0_a = 1'b0, w1_in0_b = 1'b0, w1_in1_a = 1'b0, w1_in1_b = 1'b0;
    logic w1_out_valid, w1_out_carry, w1_out_id, w1_busy, w1_out_sum;
    logic w1_out_ready = 1'b1;

    logic [W+1:0] exp_q[$];
    logic [2:0]   exp1_q[$];
    int           n_vec = 0;
    int           n_fail = 0;
    int           cyc = 0;
    int           t_acc = 0;

    serial_add_sched #(.WIDTH(W)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_a(in0_a), .in0_b(in0_b),
        .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_a(in1_a), .in1_b(in1_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_carry(out_carry), .out_id(out_id), .busy(busy)
    );

    serial_add_sched #(.WIDTH(1)) u_dut_w1 (
        .clk(clk), .rst_n(rst_n),
        .in0_valid(w1_in0_valid), .in0_ready(w1_in0_ready), .in0_a(w1_in0_a), .in0_b(w1_in0_b),
        .in1_valid(w1_in1_valid), .in1_ready(w1_in1_ready), .in1_a(w1_in1_a), .in1_b(w1_in1_b),
        .out_valid(w1_out_valid), .out_ready(w1_out_ready), .out_sum(w1_out_sum),
        .out_carry(w1_out_carry), .out_id(w1_out_id), .busy(w1_busy)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [W+1:0] model(input logic id, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
`ifdef SERIAL_ADD_CARRY_EN
        s = {1'b0, a} + {1'b0, b};
`else
        s = {1'b0, a ^ b};
`endif
        return {id, s};
    endfunction

    function automatic logic [2:0] model1(input logic a, input logic b);
`ifdef SERIAL_ADD_CARRY_EN
        return {1'b0, a & b, a ^ b};
`else
        return {1'b0, 1'b0, a ^ b};
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Driver: present operands on one port, wait for the accept, then drop valid.
    task automatic send(input logic p, input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        @(negedge clk);
        if (p) begin
            in1_valid = 1'b1; in1_a = a; in1_b = b;
        end else begin
            in0_valid = 1'b1; in0_a = a; in0_b = b;
        end
        #1;
        n = 0;
        while (!(p ? in1_ready : in0_ready) && n < 30) begin
            @(negedge clk); #1; n++;
        end
        check("send_ready", p ? in1_ready : in0_ready, 1);
        check("send_other_ready", p ? in0_ready : in1_ready, 0);
        t_acc = cyc;
        exp_q.push_back(model(p, a, b));
        @(posedge clk); #1;
        if (p) in1_valid = 1'b0; else in0_valid = 1'b0;
    endtask

    // Scoreboard side: wait for out_valid, check latency and payload, consume it.
    task automatic get_result(input string tag, input int exp_lat);
        int n;
        logic [W+1:0] e;
        @(negedge clk); #1;
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk); #1; n++;
        end
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_latency"}, cyc - t_acc, exp_lat);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check({tag, "_data"}, {out_id, out_carry, out_sum}, e);
        @(negedge clk); #1;
        check({tag, "_idle_after"}, busy, 0);
    endtask

    task automatic w1_op(input logic a, input logic b);
        int n;
        logic [2:0] e;
        @(negedge clk);
        w1_in0_valid = 1'b1; w1_in0_a = a; w1_in0_b = b;
        #1;
        n = 0;
        while (!w1_in0_ready && n < 10) begin
            @(negedge clk); #1; n++;
        end
        check("w1_ready", w1_in0_ready, 1);
        t_acc = cyc;
        exp1_q.push_back(model1(a, b));
        @(posedge clk); #1;
        w1_in0_valid = 1'b0;
        @(negedge clk); #1;
        n = 0;
        while (!w1_out_valid && n < 10) begin
            @(negedge clk); #1; n++;
        end
        check("w1_latency", cyc - t_acc, 2);
        e = (exp1_q.size() > 0) ? exp1_q.pop_front() : 'x;
        check("w1_data", {w1_out_id, w1_out_carry, w1_out_sum}, e);
        @(negedge clk); #1;
    endtask

    initial begin
        int k, results, last_acc, n;
        logic pend;
        logic pend_port;
        logic [W+1:0] e;

        // Reset state
        #2;
        check("rst_outputs", {out_valid, out_sum, out_carry, out_id, busy, in0_ready, in1_ready}, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Single operations on each port
        send(1'b0, 8'h0F, 8'h01);
        get_result("p0_0f_01", W + 1);
        send(1'b1, 8'hFF, 8'h01);
        get_result("p1_ff_01", W + 1);

        // Both ports requesting continuously from reset
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        in0_a = 8'h3C; in0_b = 8'hA7; in1_a = 8'h81; in1_b = 8'h7F;
        in0_valid = 1'b1; in1_valid = 1'b1;
        k = 0; results = 0; last_acc = 0; pend = 1'b0; pend_port = 1'b0; n = 0;
        #1;
        while (results < 4 && n < 80) begin
            if (pend) begin
                if (pend_port) begin
                    in1_a = W'($urandom_range(0, 255)); in1_b = W'($urandom_range(0, 255));
                end else begin
                    in0_a = W'($urandom_range(0, 255)); in0_b = W'($urandom_range(0, 255));
                end
                pend = 1'b0;
            end
            if (in0_ready || in1_ready) begin
                check("tie_one_ready", in0_ready & in1_ready, 0);
                check("tie_grant_order", in1_ready, k % 2);
                if (k > 0) check("tie_accept_gap", cyc - last_acc, W + 2);
                if (k % 2 == 1) exp_q.push_back(model(1'b1, in1_a, in1_b));
                else            exp_q.push_back(model(1'b0, in0_a, in0_b));
                last_acc = cyc;
                pend = 1'b1;
                pend_port = (k % 2 == 1);
                k++;
            end
            if (out_valid) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                check("tie_result", {out_id, out_carry, out_sum}, e);
                results++;
            end
            if (results < 4) begin
                @(negedge clk); #1; n++;
            end
        end
        in0_valid = 1'b0; in1_valid = 1'b0;
        check("tie_result_count", results, 4);
        check("tie_queue_empty", exp_q.size(), 0);
        @(negedge clk); @(negedge clk);

        // Output back-pressure in DONE with port 1 waiting
        out_ready = 1'b0;
        send(1'b0, 8'hC3, 8'h4E);
        in1_valid = 1'b1; in1_a = 8'h12; in1_b = 8'h34;
        n = 0;
        @(negedge clk); #1;
        while (!out_valid && n < 40) begin
            @(negedge clk); #1; n++;
        end
        check("stall_latency", cyc - t_acc, W + 1);
        e = (exp_q.size() > 0) ? exp_q[0] : 'x;
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", out_valid, 1);
            check("stall_data", {out_id, out_carry, out_sum}, e);
            check("stall_busy_ready", {busy, in0_ready, in1_ready}, 3'b100);
            @(negedge clk); #1;
        end
        void'(exp_q.pop_front());
        out_ready = 1'b1;
        @(negedge clk); #1;
        check("stall_release_idle", {busy, out_valid, in1_ready}, 3'b001);
        t_acc = cyc;
        exp_q.push_back(model(1'b1, 8'h12, 8'h34));
        @(posedge clk); #1;
        in1_valid = 1'b0;
        get_result("after_stall", W + 1);

        // Asynchronous reset in the middle of RUN
        send(1'b1, 8'h0F, 8'h02);
        repeat (3) @(posedge clk);
        #2;
        check("run_busy_before_rst", {busy, out_id}, 2'b11);
        rst_n = 1'b0;
        #1;
        check("async_rst_outputs", {out_valid, out_sum, out_carry, out_id, busy}, 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        in0_valid = 1'b1; in0_a = 8'h05; in0_b = 8'h03;
        in1_valid = 1'b1; in1_a = 8'h05; in1_b = 8'h03;
        #1;
        check("post_rst_tie", {in0_ready, in1_ready}, 2'b10);
        t_acc = cyc;
        exp_q.push_back(model(1'b0, 8'h05, 8'h03));
        @(posedge clk); #1;
        in0_valid = 1'b0;
        get_result("post_rst_p0", W + 1);
        send(1'b1, 8'h05, 8'h03);
        get_result("post_rst_p1", W + 1);

        // WIDTH=1 instance, every operand combination
        for (int i = 0; i < 4; i++) begin
            w1_op(i[1], i[0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_add_sched.md
# serial_add_sched

Two-requester scheduler that time-shares a single 1-bit add slice to perform WIDTH-bit additions bit-serially, LSB first. It arbitrates round-robin between two operand ports, sequences the slice for WIDTH cycles with a registered carry, and holds the result on a valid/ready output port. It sits between operand producers and the result consumer wherever a full-width adder is too costly.

## Interface
- WIDTH, 8: operand/result width in bits; legal range ≥ 1.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock, asynchronous, active-low.
- in0_valid  in  1  port 0 operands valid.
- in0_ready  out  1  port 0 accepted this cycle.
- in0_a, in0_b  in  WIDTH  port 0 operands.
- in1_valid  in  1  port 1 operands valid.
- in1_ready  out  1  port 1 accepted this cycle.
- in1_a, in1_b  in  WIDTH  port 1 operands.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_sum  out  WIDTH  result.
- out_carry  out  1  carry out of bit WIDTH-1.
- out_id  out  1  port that issued this result.
- busy  out  1  high in RUN or DONE.

## Operation
- States: IDLE, RUN, DONE. Reset state IDLE.
- IDLE: grant computed combinationally. Only one valid: that port is granted. Both valid: the port other than last_grant is granted. inX_ready = (state==IDLE) && granted==X. Ready depends on valid. At most one ready is high per cycle.
- Handshake (valid && ready): capture a, b, port id. Clear carry and bit index. Update last_grant. Go to RUN.
- RUN: each cycle, slice i computes s = a[i]^b[i]^c. With the macro, c_next = majority(a[i],b[i],c). Write s to sum[i]. Increment i. After bit WIDTH-1, go to DONE.
- DONE: out_valid=1. out_sum, out_carry and out_id are held stable. On out_valid && out_ready, go to IDLE.
- Input ports are not ready outside IDLE. Requests are never dropped; the requester holds valid.
- Reset values: in0_ready=0, in1_ready=0 (no valid during reset), out_valid=0, out_sum=0, out_carry=0, out_id=0, busy=0, last_grant=1. Port 0 wins the first tie.
- Reset at any point aborts the operation and discards partial results. No output is produced for an aborted operation.
- out_valid deasserts only via handshake or reset.

## Timing
- Accept on edge T. RUN occupies cycles T+1..T+WIDTH. out_valid is high from T+WIDTH+1.
- Latency: WIDTH+1 cycles from accept to out_valid.
- Output handshake on edge U: state is IDLE at U+1. No same-cycle bypass; the next accept is at earliest edge U+1.
- Peak throughput: one operation per WIDTH+2 cycles.
- WIDTH=1: a single RUN cycle.

## Configuration
- SERIAL_ADD_CARRY_EN defined:
  - Carry register is active.
  - out_sum = (a+b) mod 2^WIDTH.
  - out_carry = bit WIDTH of a+b.
- Undefined:
  - Carry is tied to 0 and the carry register is removed.
  - out_sum = a^b (carry-less add, identical to the existing 1-bit adder per bit).
  - out_carry = 0.
- Timing and handshakes are identical in both builds.

## Test plan
- WIDTH=8, port 0 a=0x0F b=0x01, out_ready=1:
  - with macro: out_sum=0x10, carry=0, id=0, out_valid 9 cycles after accept.
  - without macro: out_sum=0x0E.
- Port 1 a=0xFF b=0x01:
  - with macro: out_sum=0x00, out_carry=1, out_id=1.
  - without macro: out_sum=0xFE, out_carry=0.
- Both ports valid continuously from reset, out_ready=1:
  - results come out in order id 0,1,0,1.
  - only one inX_ready is high per accept.
  - accepts are 10 cycles apart.
- out_ready low for 5 cycles in DONE:
  - out_valid, out_sum, out_carry and out_id are stable.
  - busy=1, in0_ready=in1_ready=0.
  - release: IDLE next cycle.
- rst_n low during RUN at bit 3:
  - all outputs 0 asynchronously.
  - after release, a=0x05 b=0x03 gives 0x08 (macro) / 0x06 (no macro), and the first tie goes to port 0.
- WIDTH=1, all four a/b combos:
  - sums 0,1,1,0.
  - out_carry=1 only for 1+1 with macro; always 0 without.
  - latency 2 cycles.
